// File: rtl/loom_clk_pkg.sv
// Shared opcode, state and halt-cause encodings for the loom clock controller.
package loom_clk_pkg;

    typedef enum logic [1:0] {
        OpStop = 2'd0,
        OpRun  = 2'd1,
        OpStep = 2'd2,
        OpClr  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StStep = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CauseNone     = 2'd0,
        CauseCmdStop  = 2'd1,
        CauseStepDone = 2'd2,
        CauseBreak    = 2'd3
    } cause_e;

endpackage

// File: rtl/loom_clk_ctrl.sv
// Run/stop/single-step controller producing a registered clock enable for a gating cell,
// with halt-cause reporting and an enabled-cycle counter.
module loom_clk_ctrl
    import loom_clk_pkg::*;
#(
    parameter int unsigned CountWidth = 32,
    parameter int unsigned CycleWidth = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [1:0]            cmd_op_i,
    input  logic [CountWidth-1:0] cmd_count_i,
    input  logic                  stop_req_i,
    output logic                  ce_o,
    output logic                  running_o,
    output logic                  done_o,
    output logic [1:0]            cause_o,
    output logic                  err_o,
    output logic [CountWidth-1:0] remaining_o,
    output logic [CycleWidth-1:0] cycle_count_o
);

    state_e                state_q, state_d;
    cause_e                cause_q, cause_d, halt_cause;
    logic                  halt;
    logic                  ce_q, ce_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [CountWidth-1:0] remaining_q, remaining_d;
    logic [CycleWidth-1:0] cycle_q, cycle_d;
    op_e                   op;

    assign op          = op_e'(cmd_op_i);
    assign cmd_ready_o = 1'b1;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Halt causes are resolved here so BREAK beats CMD_STOP beats STEP_DONE.
    always_comb begin
        state_d    = state_q;
        halt       = 1'b0;
        halt_cause = CauseNone;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    if (op == OpRun) begin
                        state_d = StRun;
                    end else if (op == OpStep && cmd_count_i != '0) begin
                        state_d = StStep;
                    end
                end
            end
            StRun, StStep: begin
                halt = 1'b1;
                if (stop_req_i) begin
                    halt_cause = CauseBreak;
                end else if (cmd_valid_i && op == OpStop) begin
                    halt_cause = CauseCmdStop;
                end else if (state_q == StStep && remaining_q == CountWidth'(1)) begin
                    halt_cause = CauseStepDone;
                end else begin
                    halt = 1'b0;
                end
                if (halt) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ce_d        = (state_d != StIdle);
        done_d      = halt;
        err_d       = 1'b0;
        cause_d     = halt ? halt_cause : cause_q;
        remaining_d = remaining_q;
        cycle_d     = cycle_q + CycleWidth'(ce_q);
        if (state_q == StIdle) begin
            if (cmd_valid_i) begin
                if (op == OpStep) begin
                    if (cmd_count_i == '0) begin
                        done_d  = 1'b1;
                        cause_d = CauseStepDone;
                    end else begin
                        remaining_d = cmd_count_i;
                    end
                end else if (op == OpClr) begin
                    cycle_d = '0;
                    cause_d = CauseNone;
                end
            end
        end else begin
            err_d = cmd_valid_i && (op != OpStop);
            if (halt) begin
                remaining_d = '0;
            end else if (state_q == StStep) begin
                remaining_d = remaining_q - CountWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ce_q        <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cause_q     <= CauseNone;
            remaining_q <= '0;
            cycle_q     <= '0;
        end else begin
            ce_q        <= ce_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cause_q     <= cause_d;
            remaining_q <= remaining_d;
            cycle_q     <= cycle_d;
        end
    end

    assign ce_o          = ce_q;
    assign running_o     = (state_q != StIdle);
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign cause_o       = cause_q;
    assign remaining_o   = remaining_q;
    assign cycle_count_o = cycle_q;

endmodule

// File: tb/tb_loom_clk_ctrl.sv
// Bench for loom_clk_ctrl: directed scenarios plus a randomized run against a cycle model.
module tb_loom_clk_ctrl;

    localparam int CW = 16;
    localparam int YW = 8;
    localparam logic [1:0] OP_STOP = 2'd0, OP_RUN = 2'd1, OP_STEP = 2'd2, OP_CLR = 2'd3;
    localparam logic [1:0] C_NONE = 2'd0, C_STOP = 2'd1, C_SDONE = 2'd2, C_BREAK = 2'd3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'd0;
    logic [CW-1:0] cmd_count = '0;
    logic          stop_req = 1'b0;
    logic          ce, running, done, err;
    logic [1:0]    cause;
    logic [CW-1:0] remaining;
    logic [YW-1:0] cycle_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: mode 0 idle, 1 free-running, 2 counting down a step budget.
    int          m_mode = 0;
    int unsigned m_left = 0;
    logic [YW-1:0] m_cnt = '0;
    logic [1:0]  m_cause = C_NONE;
    bit          m_done = 0, m_err = 0;

    loom_clk_ctrl #(.CountWidth(CW), .CycleWidth(YW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_op_i     (cmd_op),
        .cmd_count_i  (cmd_count),
        .stop_req_i   (stop_req),
        .ce_o         (ce),
        .running_o    (running),
        .done_o       (done),
        .cause_o      (cause),
        .err_o        (err),
        .remaining_o  (remaining),
        .cycle_count_o(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic drive(input bit v, input logic [1:0] op, input int unsigned n, input bit sr);
        cmd_valid = v;
        cmd_op    = op;
        cmd_count = CW'(n);
        stop_req  = sr;
    endtask

    // Advance one clock, updating the model from the inputs presented at that edge.
    task automatic tick();
        int          mode_n  = m_mode;
        int unsigned left_n  = m_left;
        logic [YW-1:0] cnt_n = m_cnt;
        logic [1:0]  cause_n = m_cause;
        logic [1:0]  hc      = C_NONE;
        bit          done_n  = 0, err_n = 0, halt = 0;
        if (!rst_n) begin
            mode_n = 0; left_n = 0; cnt_n = '0; cause_n = C_NONE;
        end else begin
            if (m_mode != 0) cnt_n = m_cnt + 1'b1;
            if (m_mode == 0) begin
                if (cmd_valid && cmd_op == OP_RUN) mode_n = 1;
                if (cmd_valid && cmd_op == OP_STEP) begin
                    if (cmd_count == 0) begin
                        done_n = 1; cause_n = C_SDONE;
                    end else begin
                        mode_n = 2; left_n = cmd_count;
                    end
                end
                if (cmd_valid && cmd_op == OP_CLR) begin
                    cnt_n = '0; cause_n = C_NONE;
                end
            end else begin
                err_n = cmd_valid && cmd_op != OP_STOP;
                halt = 1;
                if (stop_req) hc = C_BREAK;
                else if (cmd_valid && cmd_op == OP_STOP) hc = C_STOP;
                else if (m_mode == 2 && m_left == 1) hc = C_SDONE;
                else halt = 0;
                if (halt) begin
                    mode_n = 0; left_n = 0; done_n = 1; cause_n = hc;
                end else if (m_mode == 2) begin
                    left_n = m_left - 1;
                end
            end
        end
        @(posedge clk);
        m_mode = mode_n; m_left = left_n; m_cnt = cnt_n; m_cause = cause_n;
        m_done = done_n; m_err = err_n;
        #1;
    endtask

    task automatic do_reset();
        drive(0, OP_STOP, 0, 0);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        drive(1, OP_RUN, 0, 1);
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++; if (ce !== 1'b0) begin n_bad++; $display("FAIL reset_ce: got %b want 0", ce); end
        n_cmp++; if (done !== 1'b0 || err !== 1'b0) begin
            n_bad++; $display("FAIL reset_pulses: got done=%b err=%b want 0 0", done, err); end
        n_cmp++; if (cause !== C_NONE) begin n_bad++; $display("FAIL reset_cause: got %0d want 0", cause); end
        n_cmp++; if (remaining !== '0 || cycle_count !== '0) begin
            n_bad++; $display("FAIL reset_counts: got rem=%0d cyc=%0d want 0 0", remaining, cycle_count); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL cmd_ready: got %b want 1", cmd_ready); end
        rst_n = 1'b1;
        drive(0, OP_STOP, 0, 0);
    endtask

    // RUN, then STOP presented in enabled cycle k: expect k enabled cycles.
    task automatic test_run_stop(input int k, input int exp_cnt, input string tag);
        int ce_cycles = 0;
        do_reset();
        drive(1, OP_RUN, 0, 0);
        tick();
        if (ce === 1'b1) ce_cycles++;
        drive(0, OP_STOP, 0, 0);
        for (int i = 1; i < k; i++) begin
            tick();
            if (ce === 1'b1) ce_cycles++;
        end
        drive(1, OP_STOP, 0, 0);
        tick();
        drive(0, OP_STOP, 0, 0);
        n_cmp++; if (ce_cycles != k) begin n_bad++; $display("FAIL %s_ce_cycles: got %0d want %0d", tag, ce_cycles, k); end
        n_cmp++; if (ce !== 1'b0 || done !== 1'b1) begin
            n_bad++; $display("FAIL %s_halt: got ce=%b done=%b want 0 1", tag, ce, done); end
        n_cmp++; if (cause !== C_STOP) begin n_bad++; $display("FAIL %s_cause: got %0d want 1", tag, cause); end
        n_cmp++; if (cycle_count !== YW'(exp_cnt)) begin
            n_bad++; $display("FAIL %s_count: got %0d want %0d", tag, cycle_count, exp_cnt); end
        tick();
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL %s_done_once: got %b want 0", tag, done); end
    endtask

    task automatic test_step5();
        do_reset();
        drive(1, OP_STEP, 5, 0);
        tick();
        drive(0, OP_STOP, 0, 0);
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (ce !== 1'b1 || remaining !== CW'(5 - i) || done !== 1'b0) begin
                n_bad++;
                $display("FAIL step5_cycle%0d: got ce=%b rem=%0d done=%b want 1 %0d 0", i, ce, remaining, done, 5 - i);
            end
            tick();
        end
        n_cmp++; if (ce !== 1'b0 || remaining !== '0 || done !== 1'b1) begin
            n_bad++; $display("FAIL step5_end: got ce=%b rem=%0d done=%b want 0 0 1", ce, remaining, done); end
        n_cmp++; if (cause !== C_SDONE || cycle_count !== 8'd5) begin
            n_bad++; $display("FAIL step5_status: got cause=%0d cyc=%0d want 2 5", cause, cycle_count); end
        tick();
        n_cmp++; if (done !== 1'b0 || running !== 1'b0) begin
            n_bad++; $display("FAIL step5_after: got done=%b running=%b want 0 0", done, running); end
    endtask

    // Runs right after test_step5: cause is STEP_DONE and five cycles counted.
    task automatic test_step0_and_idle_stop();
        int ce_seen = 0;
        drive(1, OP_STOP, 0, 1);
        tick();
        n_cmp++; if (done !== 1'b0 || err !== 1'b0 || cause !== C_SDONE || ce !== 1'b0) begin
            n_bad++; $display("FAIL idle_stop: got done=%b err=%b cause=%0d ce=%b want 0 0 2 0", done, err, cause, ce); end
        drive(1, OP_CLR, 0, 0);
        tick();
        n_cmp++; if (cause !== C_NONE || cycle_count !== '0) begin
            n_bad++; $display("FAIL idle_clr: got cause=%0d cyc=%0d want 0 0", cause, cycle_count); end
        drive(1, OP_STEP, 0, 0);
        tick();
        if (ce === 1'b1) ce_seen++;
        drive(0, OP_STOP, 0, 0);
        n_cmp++; if (done !== 1'b1 || cause !== C_SDONE) begin
            n_bad++; $display("FAIL step0_done: got done=%b cause=%0d want 1 2", done, cause); end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ce === 1'b1) ce_seen++;
        end
        n_cmp++; if (ce_seen != 0 || cycle_count !== '0 || done !== 1'b0) begin
            n_bad++; $display("FAIL step0_quiet: got ce_seen=%0d cyc=%0d done=%b want 0 0 0", ce_seen, cycle_count, done); end
    endtask

    task automatic test_break();
        do_reset();
        drive(1, OP_STEP, 100, 0);
        tick();
        drive(0, OP_STOP, 0, 0);
        tick();
        tick();
        n_cmp++; if (remaining !== CW'(98)) begin n_bad++; $display("FAIL break_rem3: got %0d want 98", remaining); end
        drive(0, OP_STOP, 0, 1);
        tick();
        drive(0, OP_STOP, 0, 0);
        n_cmp++; if (ce !== 1'b0 || done !== 1'b1 || cause !== C_BREAK) begin
            n_bad++; $display("FAIL break_halt: got ce=%b done=%b cause=%0d want 0 1 3", ce, done, cause); end
        n_cmp++; if (cycle_count !== 8'd3 || remaining !== '0) begin
            n_bad++; $display("FAIL break_counts: got cyc=%0d rem=%0d want 3 0", cycle_count, remaining); end
        drive(0, OP_STOP, 0, 1);
        tick();
        n_cmp++; if (done !== 1'b0 || ce !== 1'b0) begin
            n_bad++; $display("FAIL break_idle_ignore: got done=%b ce=%b want 0 0", done, ce); end
        drive(0, OP_STOP, 0, 0);
    endtask

    task automatic test_priority();
        int dones = 0;
        do_reset();
        drive(1, OP_STEP, 2, 0);
        tick();
        drive(0, OP_STOP, 0, 0);
        tick();
        drive(1, OP_STOP, 0, 1);
        tick();
        drive(0, OP_STOP, 0, 0);
        if (done === 1'b1) dones++;
        n_cmp++; if (cause !== C_BREAK || cycle_count !== 8'd2) begin
            n_bad++; $display("FAIL prio_cause: got cause=%0d cyc=%0d want 3 2", cause, cycle_count); end
        tick();
        if (done === 1'b1) dones++;
        n_cmp++; if (dones != 1) begin n_bad++; $display("FAIL prio_single_done: got %0d want 1", dones); end
    endtask

    task automatic test_illegal_clr_reset();
        do_reset();
        drive(1, OP_RUN, 0, 0);
        tick();
        drive(1, OP_STEP, 7, 0);
        tick();
        drive(0, OP_STOP, 0, 0);
        n_cmp++; if (err !== 1'b1 || running !== 1'b1 || ce !== 1'b1 || remaining !== '0) begin
            n_bad++; $display("FAIL illegal_step: got err=%b run=%b ce=%b rem=%0d want 1 1 1 0", err, running, ce, remaining); end
        tick();
        n_cmp++; if (err !== 1'b0 || running !== 1'b1) begin
            n_bad++; $display("FAIL illegal_after: got err=%b run=%b want 0 1", err, running); end
        drive(1, OP_STOP, 0, 0);
        tick();
        drive(1, OP_CLR, 0, 0);
        tick();
        n_cmp++; if (cycle_count !== '0 || cause !== C_NONE || err !== 1'b0) begin
            n_bad++; $display("FAIL clr: got cyc=%0d cause=%0d err=%b want 0 0 0", cycle_count, cause, err); end
        drive(1, OP_RUN, 0, 0);
        tick();
        drive(0, OP_STOP, 0, 0);
        tick();
        rst_n = 1'b0;
        tick();
        n_cmp++; if (ce !== 1'b0 || done !== 1'b0 || running !== 1'b0) begin
            n_bad++; $display("FAIL reset_mid_run: got ce=%b done=%b run=%b want 0 0 0", ce, done, running); end
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), $urandom_range(0, 6),
                  $urandom_range(0, 15) == 0);
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
            n_cmp++; if (ce !== (m_mode != 0) || running !== (m_mode != 0)) begin
                n_bad++; $display("FAIL rnd_ce c%0d: got ce=%b run=%b want %0d", c, ce, running, m_mode != 0); end
            n_cmp++; if (done !== m_done || err !== m_err) begin
                n_bad++; $display("FAIL rnd_pulse c%0d: got done=%b err=%b want %b %b", c, done, err, m_done, m_err); end
            n_cmp++; if (cause !== m_cause) begin
                n_bad++; $display("FAIL rnd_cause c%0d: got %0d want %0d", c, cause, m_cause); end
            n_cmp++; if (remaining !== CW'(m_left) || cycle_count !== m_cnt) begin
                n_bad++; $display("FAIL rnd_counts c%0d: got rem=%0d cyc=%0d want %0d %0d", c, remaining, cycle_count, m_left, m_cnt); end
        end
        rst_n = 1'b1;
        drive(0, OP_STOP, 0, 0);
    endtask

    initial begin
        test_reset();
        test_run_stop(10, 10, "run10");
        test_step5();
        test_step0_and_idle_stop();
        test_break();
        test_priority();
        test_illegal_clr_reset();
        test_run_stop(260, 4, "wrap");
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/loom_clk_ctrl.md
LOOM_CLK_CTRL -- requirements
Module: loom_clk_ctrl

Interface
REQ-001 SHALL have parameter CountWidth, default 32, width of the step count and remaining count.
REQ-002 SHALL have parameter CycleWidth, default 64, width of the enabled-cycle counter.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1, synchronous active-low reset.
REQ-005 SHALL have port cmd_valid_i, input, 1, command valid.
REQ-006 SHALL have port cmd_ready_o, output, 1, command ready; tied to 1.
REQ-007 SHALL have port cmd_op_i, input, 2, command opcode: STOP=0, RUN=1, STEP=2, CLR=3.
REQ-008 SHALL have port cmd_count_i, input, CountWidth, step count; used only by STEP.
REQ-009 SHALL have port stop_req_i, input, 1, breakpoint/trigger halt request from the DUT.
REQ-010 SHALL have port ce_o, output, 1, registered clock enable that drives the gating cell.
REQ-011 SHALL have port running_o, output, 1, high in the RUN and STEP states.
REQ-012 SHALL have port done_o, output, 1, one-cycle pulse on every transition to IDLE.
REQ-013 SHALL have port cause_o, output, 2, last halt cause: NONE=0, CMD_STOP=1, STEP_DONE=2, BREAK=3.
REQ-014 SHALL have port err_o, output, 1, one-cycle pulse when an accepted command is illegal in the current state.
REQ-015 SHALL have port remaining_o, output, CountWidth, enabled cycles still left in the current STEP.
REQ-016 SHALL have port cycle_count_o, output, CycleWidth, total enabled cycles.

Function
REQ-017 SHALL accept a command in any cycle where cmd_valid_i=1, because cmd_ready_o=1.
REQ-018 SHALL implement the states IDLE, RUN and STEP.
REQ-019 SHALL, on RUN accepted in IDLE, go to RUN and set ce_o=1 from the next cycle until halted.
REQ-020 SHALL, on STEP with N>0 accepted in IDLE, go to STEP, load remaining_o=N, and hold ce_o=1 for exactly N consecutive cycles starting the next cycle.
REQ-021 SHALL decrement remaining_o by 1 in each STEP cycle with ce_o=1.
REQ-022 SHALL, in the cycle after the last STEP cycle with ce_o=1, have ce_o=0, state IDLE, done_o=1 and cause_o=STEP_DONE.
REQ-023 SHALL, on STEP with N=0 in IDLE, not assert ce_o, pulse done_o in the next cycle and set cause_o=STEP_DONE.
REQ-024 SHALL, on STOP accepted in RUN or STEP, have ce_o=0, state IDLE, done_o=1 and cause_o=CMD_STOP in the next cycle.
REQ-025 SHALL, when stop_req_i=1 in RUN or STEP, have ce_o=0, state IDLE, done_o=1 and cause_o=BREAK in the next cycle.
REQ-026 SHALL ignore stop_req_i in IDLE.
REQ-027 SHALL prioritise halt causes occurring in the same cycle as BREAK, then CMD_STOP, then STEP_DONE.
REQ-028 SHALL treat STOP in IDLE as a no-op: no done_o, no err_o, cause_o unchanged.
REQ-029 SHALL treat RUN, STEP or CLR accepted in RUN or STEP as follows: command dropped, err_o pulsed next cycle, state unchanged.
REQ-030 SHALL, on CLR in IDLE, set cycle_count_o=0 and cause_o=NONE next cycle.
REQ-031 SHALL increment cycle_count_o by 1 in every cycle with ce_o=1, wrapping modulo 2^CycleWidth.
REQ-032 SHALL set remaining_o=0 when leaving STEP for any reason.
REQ-033 SHALL drive ce_o directly from a flop, glitch-free, with no combinational path from any input.

Reset
REQ-034 SHALL, while rst_ni=0 at a rising edge, set state IDLE, ce_o=0, done_o=0, err_o=0, cause_o=NONE, remaining_o=0 and cycle_count_o=0.
REQ-035 SHALL let reset during RUN or STEP drop ce_o to 0 in the next cycle without pulsing done_o.

Structure
REQ-036 SHALL define the opcode, state and cause enums in a shared package loom_clk_pkg.
REQ-037 SHALL contain no sub-module; the parent connects ce_o to a loom_clk_gate instance.

Verification
REQ-038 SHALL cover: reset, then RUN, then STOP 10 cycles later -> exactly 10 cycles with ce_o=1, cycle_count_o=10, done_o pulse, cause_o=CMD_STOP.
REQ-039 SHALL cover: STEP N=5 -> ce_o=1 for exactly 5 cycles, remaining_o goes 5,4,3,2,1,0, done_o pulses once, cause_o=STEP_DONE, cycle_count_o=5.
REQ-040 SHALL cover: STEP N=0 -> ce_o never 1, done_o pulses the next cycle, cycle_count_o unchanged.
REQ-041 SHALL cover: STEP N=100 with stop_req_i=1 in STEP cycle 3 -> ce_o=0 next cycle, cycle_count_o=3, cause_o=BREAK, remaining_o=0.
REQ-042 SHALL cover: STEP N=2 with STOP and stop_req_i in the final enabled cycle -> cause_o=BREAK, single done_o pulse.
REQ-043 SHALL cover: RUN followed by STEP while running -> err_o pulse, still RUN; then STOP and CLR -> cycle_count_o=0, cause_o=NONE; rst_ni=0 mid-RUN -> ce_o=0 next cycle, no done_o.
